fft_bin_capture: RTL

FFT_BIN_CAPTURE -- requirements
Module: fft_bin_capture

---
 rtl/fft_bin_capture.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fft_bin_capture.sv
// Selects the strongest voltage bin in the lower half of an FFT frame and captures
// its V/I components, then hands them to a CORDIC stage and waits for completion.
module fft_bin_capture #(
    parameter int N  = 256,
    parameter int DW = 16,
    parameter int BW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fft_reset,
    input  logic          src_valid,
    input  logic          src_sop,
    input  logic          src_eop,
    input  logic [DW-1:0] v_re,
    input  logic [DW-1:0] v_im,
    input  logic [DW-1:0] i_re,
    input  logic [DW-1:0] i_im,
    output logic          cordic_req,
    input  logic          cordic_ack,
    output logic          end_cordic,
    output logic [BW-1:0] pk_bin,
    output logic [DW-1:0] pk_v_re,
    output logic [DW-1:0] pk_v_im,
    output logic [DW-1:0] pk_i_re,
    output logic [DW-1:0] pk_i_im,
    output logic          result_valid,
    output logic          frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [BW-1:0] LAST_BIN = BW'(N - 1);
    localparam logic [BW-1:0] HALF_BIN = BW'(N / 2);

    state_t        state_q;
    logic [BW-1:0] cnt_q;
    logic [DW:0]   best_q;
    logic [BW-1:0] cand_bin_q;
    logic [DW-1:0] cand_v_re_q, cand_v_im_q, cand_i_re_q, cand_i_im_q;
    logic [BW-1:0] pk_bin_q;
    logic [DW-1:0] pk_v_re_q, pk_v_im_q, pk_i_re_q, pk_i_im_q;
    logic          cordic_req_q, end_cordic_q, result_valid_q, frame_err_q;

    logic [BW-1:0] idx_d;
    logic [DW:0]   m_d;
    logic          cand_hit_d;

    // |x| widened by one bit so the most negative input maps to 2^(DW-1) exactly
    function automatic logic [DW:0] mag(input logic [DW-1:0] x);
        logic [DW:0] ext;
        ext = {x[DW-1], x};
        return x[DW-1] ? (~ext + (DW+1)'(1)) : ext;
    endfunction

    always_comb begin
        m_d        = mag(v_re) + mag(v_im);
        idx_d      = src_sop ? '0 : cnt_q + BW'(1);
        cand_hit_d = (idx_d != '0) && (idx_d < HALF_BIN) && (m_d > best_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            best_q         <= '0;
            cand_bin_q     <= '0;
            cand_v_re_q    <= '0;
            cand_v_im_q    <= '0;
            cand_i_re_q    <= '0;
            cand_i_im_q    <= '0;
            pk_bin_q       <= '0;
            pk_v_re_q      <= '0;
            pk_v_im_q      <= '0;
            pk_i_re_q      <= '0;
            pk_i_im_q      <= '0;
            cordic_req_q   <= 1'b0;
            end_cordic_q   <= 1'b0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else if (fft_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cordic_req_q <= 1'b0;
            end_cordic_q <= 1'b0;
        end else begin
            cordic_req_q <= 1'b0;
            end_cordic_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (src_valid && (src_sop || state_q == ST_COLLECT)) begin
                        if (src_sop) begin
                            // bin 0 is never a candidate, so a frame start only seeds the search
                            cnt_q       <= '0;
                            best_q      <= '0;
                            cand_bin_q  <= BW'(1);
                            cand_v_re_q <= '0;
                            cand_v_im_q <= '0;
                            cand_i_re_q <= '0;
                            cand_i_im_q <= '0;
                            if (state_q == ST_COLLECT) begin
                                frame_err_q <= 1'b1;
                            end else begin
                                result_valid_q <= 1'b0;
                            end
                            if (src_eop) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                state_q <= ST_COLLECT;
                            end
                        end else if (cnt_q == LAST_BIN) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            cnt_q <= idx_d;
                            if (cand_hit_d) begin
                                best_q      <= m_d;
                                cand_bin_q  <= idx_d;
                                cand_v_re_q <= v_re;
                                cand_v_im_q <= v_im;
                                cand_i_re_q <= i_re;
                                cand_i_im_q <= i_im;
                            end
                            if (src_eop) begin
                                if (idx_d == LAST_BIN) begin
                                    // the last bin is never a candidate, so the held set is final
                                    pk_bin_q     <= cand_bin_q;
                                    pk_v_re_q    <= cand_v_re_q;
                                    pk_v_im_q    <= cand_v_im_q;
                                    pk_i_re_q    <= cand_i_re_q;
                                    pk_i_im_q    <= cand_i_im_q;
                                    cordic_req_q <= 1'b1;
                                    state_q      <= ST_REQ;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= ST_IDLE;
                                end
                            end
                        end
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cordic_ack) begin
                        end_cordic_q   <= 1'b1;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cordic_req   = cordic_req_q;
    assign end_cordic   = end_cordic_q;
    assign pk_bin       = pk_bin_q;
    assign pk_v_re      = pk_v_re_q;
    assign pk_v_im      = pk_v_im_q;
    assign pk_i_re      = pk_i_re_q;
    assign pk_i_im      = pk_i_im_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;

endmodule
